// File: rtl/fwd_pkg.sv
// Shared types and select codes for the forwarding/hazard controller.
package fwd_pkg;

  localparam int DEFAULT_REG_ADDR_W = 5;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef struct packed {
    logic                          valid;
    logic [DEFAULT_REG_ADDR_W-1:0] rd;
    logic                          wr;
    logic                          is_load;
    logic                          is_mul;
  } stage_info_t;

  // x0 is hard-wired zero, so it never has a producer.
  function automatic logic is_producer(stage_info_t s, logic [DEFAULT_REG_ADDR_W-1:0] r);
    return s.valid && s.wr && (s.rd == r) && (r != '0);
  endfunction

endpackage

// File: rtl/fwd_src_sel.sv
// Operand select for one EX source: compares against EX and MEM shadows, youngest wins.
module fwd_src_sel
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] src_i,
  input  logic                  used_i,
  input  logic                  ex_valid_i,
  input  logic                  ex_wr_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  mem_valid_i,
  input  logic                  mem_wr_i,
  input  logic [REG_ADDR_W-1:0] mem_rd_i,
  output logic [1:0]            sel_o
);

  logic src_live;
  logic ex_hit;
  logic mem_hit;

  assign src_live = used_i && (src_i != '0);
  assign ex_hit   = src_live && ex_valid_i && ex_wr_i && (ex_rd_i == src_i);
  assign mem_hit  = src_live && mem_valid_i && mem_wr_i && (mem_rd_i == src_i);

  always_comb begin
    sel_o = FWD_RF;
    if (ex_hit) begin
      sel_o = FWD_EXMEM;
    end else if (mem_hit) begin
      sel_o = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard control for the 5-stage pipeline with a multi-cycle multiplier.
// Define HAZARD_STATS_EN to add the saturating stall_cycles / fwd_events counters.
module fwd_hazard_ctrl
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W,
  parameter int MUL_LAT    = 3
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_is_load,
  input  logic                  id_is_mul,
  output logic                  stall,
  output logic                  ex_bubble,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]           stall_cycles,
  output logic [15:0]           fwd_events
`endif
);

  localparam int CNT_W = $clog2(MUL_LAT);

  stage_info_t      ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  logic [CNT_W-1:0] mul_cnt_q, mul_cnt_d;
  logic [1:0]       sel_a_q, sel_a_d, sel_b_q, sel_b_d;
  logic [1:0]       sel_a_new, sel_b_new;
  logic             mul_busy;
  logic             load_use;
  logic             unused_stage_bits;

  fwd_src_sel #(.REG_ADDR_W(REG_ADDR_W)) u_sel_a (
    .src_i       (id_rs1),
    .used_i      (id_rs1_used),
    .ex_valid_i  (ex_q.valid),
    .ex_wr_i     (ex_q.wr),
    .ex_rd_i     (ex_q.rd),
    .mem_valid_i (mem_q.valid),
    .mem_wr_i    (mem_q.wr),
    .mem_rd_i    (mem_q.rd),
    .sel_o       (sel_a_new)
  );

  fwd_src_sel #(.REG_ADDR_W(REG_ADDR_W)) u_sel_b (
    .src_i       (id_rs2),
    .used_i      (id_rs2_used),
    .ex_valid_i  (ex_q.valid),
    .ex_wr_i     (ex_q.wr),
    .ex_rd_i     (ex_q.rd),
    .mem_valid_i (mem_q.valid),
    .mem_wr_i    (mem_q.wr),
    .mem_rd_i    (mem_q.rd),
    .sel_o       (sel_b_new)
  );

  // mul_cnt is loaded as the mul issues, so it counts the remaining hold edges.
  assign mul_busy  = (mul_cnt_q != '0);
  assign load_use  = id_valid && ex_q.valid && ex_q.is_load &&
                     ((id_rs1_used && is_producer(ex_q, id_rs1)) ||
                      (id_rs2_used && is_producer(ex_q, id_rs2)));
  assign stall     = mul_busy || load_use;
  assign ex_bubble = load_use && !mul_busy;

  always_comb begin
    ex_d      = ex_q;
    mem_d     = ex_q;
    wb_d      = mem_q;
    sel_a_d   = sel_a_q;
    sel_b_d   = sel_b_q;
    mul_cnt_d = mul_cnt_q;
    if (mul_busy) begin
      mem_d     = '0;
      mul_cnt_d = mul_cnt_q - CNT_W'(1);
    end else if (load_use) begin
      ex_d    = '0;
      sel_a_d = FWD_RF;
      sel_b_d = FWD_RF;
    end else begin
      ex_d = '{valid: id_valid, rd: id_rd, wr: id_reg_write,
               is_load: id_is_load, is_mul: id_is_mul};
      sel_a_d = sel_a_new;
      sel_b_d = sel_b_new;
      if (id_valid && id_is_mul) begin
        mul_cnt_d = CNT_W'(MUL_LAT - 1);
      end
    end
  end

  // ---- ID/EX boundary: shadow stages, multiplier counter, EX operand selects ----
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      mul_cnt_q <= '0;
      sel_a_q   <= FWD_RF;
      sel_b_q   <= FWD_RF;
    end else begin
      ex_q      <= ex_d;
      mem_q     <= mem_d;
      wb_q      <= wb_d;
      mul_cnt_q <= mul_cnt_d;
      sel_a_q   <= sel_a_d;
      sel_b_q   <= sel_b_d;
    end
  end

  assign fwd_a_sel = sel_a_q;
  assign fwd_b_sel = sel_b_q;

  // WB is tracked for pipeline bookkeeping only; no operand path reads it.
  assign unused_stage_bits = ^{wb_q, mem_q.is_load, mem_q.is_mul, ex_q.is_mul};

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cycles_q;
  logic [15:0] fwd_events_q;
  logic [1:0]  fwd_inc;

  function automatic logic [15:0] sat_add16(logic [15:0] a, logic [1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  always_comb begin
    fwd_inc = 2'd0;
    if (!stall) begin
      fwd_inc = {1'b0, sel_a_new != FWD_RF} + {1'b0, sel_b_new != FWD_RF};
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      stall_cycles_q <= '0;
      fwd_events_q   <= '0;
    end else begin
      stall_cycles_q <= sat_add16(stall_cycles_q, {1'b0, stall});
      fwd_events_q   <= sat_add16(fwd_events_q, fwd_inc);
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign fwd_events   = fwd_events_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed vector table, randomized run against a reference
// model, and an asynchronous reset during a multiply.
module tb_fwd_hazard_ctrl;

  localparam int MUL_LAT = 3;
  localparam int NVEC    = 18;
  localparam int NRAND   = 400;

  logic       clk = 1'b0;
  logic       arst;
  logic       id_valid, id_rs1_used, id_rs2_used, id_reg_write, id_is_load, id_is_mul;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       stall, ex_bubble;
  logic [1:0] fwd_a_sel, fwd_b_sel;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cycles, fwd_events;
`endif

  fwd_hazard_ctrl #(.REG_ADDR_W(5), .MUL_LAT(MUL_LAT)) dut (
    .clk          (clk),
    .arst         (arst),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_is_load   (id_is_load),
    .id_is_mul    (id_is_mul),
    .stall        (stall),
    .ex_bubble    (ex_bubble),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cycles (stall_cycles),
    .fwd_events   (fwd_events)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       wr, ld, mul;
  } id_t;

  typedef struct {
    id_t        id;
    logic       es, eb;
    logic [1:0] ea, ebs;
  } vec_t;

  typedef struct {
    logic valid;
    int   rd;
    logic wr, ld, mul;
  } slot_t;

  int    nchecks = 0;
  int    nerrors = 0;
  vec_t  tbl[NVEC];
  slot_t m_ex, m_mem;
  int    m_mul_left, m_a, m_b, m_stalls, m_fwds;

  function automatic id_t ins(logic v, int rs1, int rs2, logic u1, logic u2, int rd,
                              logic wr, logic ld, logic mul);
    id_t i;
    i.v = v; i.rs1 = 5'(rs1); i.rs2 = 5'(rs2); i.u1 = u1; i.u2 = u2;
    i.rd = 5'(rd); i.wr = wr; i.ld = ld; i.mul = mul;
    return i;
  endfunction

  function automatic vec_t vec(id_t i, logic es, logic eb, logic [1:0] ea, logic [1:0] ebs);
    vec_t r;
    r.id = i; r.es = es; r.eb = eb; r.ea = ea; r.ebs = ebs;
    return r;
  endfunction

  function automatic slot_t empty_slot();
    slot_t s;
    s.valid = 1'b0; s.rd = 0; s.wr = 1'b0; s.ld = 1'b0; s.mul = 1'b0;
    return s;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nerrors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input id_t i);
    id_valid = i.v; id_rs1 = i.rs1; id_rs2 = i.rs2;
    id_rs1_used = i.u1; id_rs2_used = i.u2; id_rd = i.rd;
    id_reg_write = i.wr; id_is_load = i.ld; id_is_mul = i.mul;
  endtask

  // Reference model: an instruction's destination is visible from EX first, then MEM.
  function automatic logic produces(slot_t s, int r);
    return s.valid && s.wr && (s.rd == r) && (r != 0);
  endfunction

  function automatic int pick(int r, logic used);
    if (!used || r == 0) return 0;
    if (produces(m_ex, r)) return 1;
    if (produces(m_mem, r)) return 2;
    return 0;
  endfunction

  task automatic model_cycle(input id_t i, output logic es, output logic eb);
    logic busy, lu;
    slot_t n;
    busy = (m_mul_left > 0);
    lu   = i.v && m_ex.valid && m_ex.ld &&
           ((i.u1 && produces(m_ex, int'(i.rs1))) || (i.u2 && produces(m_ex, int'(i.rs2))));
    es = busy || lu;
    eb = lu && !busy;
    if (es) m_stalls++;
    if (busy) begin
      m_mem = empty_slot();
      m_mul_left--;
    end else if (lu) begin
      m_mem = m_ex;
      m_ex  = empty_slot();
      m_a = 0; m_b = 0;
    end else begin
      m_a = pick(int'(i.rs1), i.u1);
      m_b = pick(int'(i.rs2), i.u2);
      m_fwds += int'(m_a != 0) + int'(m_b != 0);
      n.valid = i.v; n.rd = int'(i.rd); n.wr = i.wr; n.ld = i.ld; n.mul = i.mul;
      m_mem = m_ex;
      m_ex  = n;
      if (i.v && i.mul) m_mul_left = MUL_LAT - 1;
    end
  endtask

  task automatic do_reset();
    arst = 1'b1;
    drive(ins(0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst = 1'b0;
    m_ex = empty_slot(); m_mem = empty_slot();
    m_mul_left = 0; m_a = 0; m_b = 0; m_stalls = 0; m_fwds = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    id_t  nop, cur;
    logic es, eb, prev_stall;

    arst = 1'b1;
    nop = ins(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(nop);

    tbl[0]  = vec(ins(1, 1, 2, 1, 1, 3, 1, 0, 0), 0, 0, 2'b00, 2'b00); // add x3,x1,x2
    tbl[1]  = vec(ins(1, 3, 5, 1, 1, 4, 1, 0, 0), 0, 0, 2'b01, 2'b00); // add x4,x3,x5
    tbl[2]  = vec(nop,                            0, 0, 2'b00, 2'b00);
    tbl[3]  = vec(ins(1, 1, 2, 1, 1, 3, 1, 0, 0), 0, 0, 2'b00, 2'b00); // add x3
    tbl[4]  = vec(nop,                            0, 0, 2'b00, 2'b00);
    tbl[5]  = vec(ins(1, 3, 3, 1, 1, 6, 1, 0, 0), 0, 0, 2'b10, 2'b10); // sub x6,x3,x3
    tbl[6]  = vec(ins(1, 1, 0, 1, 0, 7, 1, 1, 0), 0, 0, 2'b00, 2'b00); // lw x7
    tbl[7]  = vec(ins(1, 7, 1, 1, 1, 8, 1, 0, 0), 1, 1, 2'b00, 2'b00); // add x8,x7,x1
    tbl[8]  = vec(ins(1, 7, 1, 1, 1, 8, 1, 0, 0), 0, 0, 2'b10, 2'b00); // held, issues
    tbl[9]  = vec(ins(1, 8, 2, 1, 1, 9, 1, 0, 1), 0, 0, 2'b01, 2'b00); // mul x9,x8,x2
    tbl[10] = vec(ins(1, 11, 12, 1, 1, 10, 1, 0, 0), 1, 0, 2'b01, 2'b00); // add x10 held
    tbl[11] = vec(ins(1, 11, 12, 1, 1, 10, 1, 0, 0), 1, 0, 2'b01, 2'b00);
    tbl[12] = vec(ins(1, 11, 12, 1, 1, 10, 1, 0, 0), 0, 0, 2'b00, 2'b00);
    tbl[13] = vec(ins(1, 9, 10, 1, 1, 13, 1, 0, 0), 0, 0, 2'b10, 2'b01); // add x13,x9,x10
    tbl[14] = vec(ins(1, 1, 2, 1, 1, 0, 1, 0, 0), 0, 0, 2'b00, 2'b00);  // add x0
    tbl[15] = vec(ins(1, 0, 0, 1, 0, 0, 1, 1, 0), 0, 0, 2'b00, 2'b00);  // lw x0,(x0)
    tbl[16] = vec(ins(1, 0, 0, 1, 1, 5, 1, 0, 0), 0, 0, 2'b00, 2'b00);  // add x5,x0,x0
    tbl[17] = vec(nop,                            0, 0, 2'b00, 2'b00);

    do_reset();
    #1;
    check("reset stall", int'(stall), 0);
    check("reset ex_bubble", int'(ex_bubble), 0);
    check("reset fwd_a_sel", int'(fwd_a_sel), 0);
    check("reset fwd_b_sel", int'(fwd_b_sel), 0);
`ifdef HAZARD_STATS_EN
    check("reset stall_cycles", int'(stall_cycles), 0);
    check("reset fwd_events", int'(fwd_events), 0);
`endif

    for (int k = 0; k < NVEC; k++) begin
      @(negedge clk);
      drive(tbl[k].id);
      #1;
      check($sformatf("vec%0d stall", k), int'(stall), int'(tbl[k].es));
      check($sformatf("vec%0d ex_bubble", k), int'(ex_bubble), int'(tbl[k].eb));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d fwd_a_sel", k), int'(fwd_a_sel), int'(tbl[k].ea));
      check($sformatf("vec%0d fwd_b_sel", k), int'(fwd_b_sel), int'(tbl[k].ebs));
    end

    do_reset();
    prev_stall = 1'b0;
    cur = nop;
    for (int n = 0; n < NRAND; n++) begin
      @(negedge clk);
      if (!prev_stall) begin
        cur.v   = ($urandom_range(0, 7) != 0);
        cur.rs1 = 5'($urandom_range(0, 7));
        cur.rs2 = 5'($urandom_range(0, 7));
        cur.u1  = 1'($urandom_range(0, 1));
        cur.u2  = 1'($urandom_range(0, 1));
        cur.rd  = 5'($urandom_range(0, 7));
        cur.wr  = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 7))
          0, 1:    begin cur.ld = 1'b1; cur.mul = 1'b0; end
          2:       begin cur.ld = 1'b0; cur.mul = 1'b1; end
          default: begin cur.ld = 1'b0; cur.mul = 1'b0; end
        endcase
      end
      drive(cur);
      model_cycle(cur, es, eb);
      #1;
      check($sformatf("rnd%0d stall", n), int'(stall), int'(es));
      check($sformatf("rnd%0d ex_bubble", n), int'(ex_bubble), int'(eb));
      @(posedge clk);
      #1;
      check($sformatf("rnd%0d fwd_a_sel", n), int'(fwd_a_sel), m_a);
      check($sformatf("rnd%0d fwd_b_sel", n), int'(fwd_b_sel), m_b);
      prev_stall = es;
    end
`ifdef HAZARD_STATS_EN
    check("rnd stall_cycles", int'(stall_cycles), m_stalls);
    check("rnd fwd_events", int'(fwd_events), m_fwds);
`endif

    // Asynchronous reset in the second EX cycle of a multiply.
    do_reset();
    @(negedge clk);
    drive(ins(1, 1, 2, 1, 1, 9, 1, 0, 1));
    @(negedge clk);
    drive(ins(1, 9, 9, 1, 1, 10, 1, 0, 0));
    #1;
    check("mul first cycle stall", int'(stall), 1);
    @(posedge clk);
    #3;
    check("mul second cycle stall", int'(stall), 1);
    arst = 1'b1;
    #1;
    check("arst mid-mul stall", int'(stall), 0);
    check("arst mid-mul ex_bubble", int'(ex_bubble), 0);
    check("arst mid-mul fwd_a_sel", int'(fwd_a_sel), 0);
    check("arst mid-mul fwd_b_sel", int'(fwd_b_sel), 0);
`ifdef HAZARD_STATS_EN
    check("arst mid-mul stall_cycles", int'(stall_cycles), 0);
    check("arst mid-mul fwd_events", int'(fwd_events), 0);
`endif
    @(negedge clk);
    arst = 1'b0;
    #1;
    check("post-arst stall", int'(stall), 0);
    @(posedge clk);
    #1;
    check("post-arst fwd_a_sel", int'(fwd_a_sel), 0);
    check("post-arst fwd_b_sel", int'(fwd_b_sel), 0);
    @(negedge clk);
    drive(nop);
    #1;
    check("post-arst second stall", int'(stall), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
